pcie_dma_reader: RTL and testbench
==================================

Name: pcie_dma_reader

Overview:
AXI4 read master that fetches a block of 512-bit beats from the PCIe-side AXI slave and forwards the returned data as an AXI-Stream. It splits a host-programmed transfer into INCR bursts that never cross a 4 KB boundary, and it keeps up to MAX_OUTSTANDING bursts in flight. It sits directly upstream of the PCIe source model, driving that model's AR and R channels, and feeds the downstream packet/stream consumers.

Parameters:
DATA_WIDTH, 512, R/stream data width in bits; bytes per beat BPB = DATA_WIDTH/8 (64).
ADDR_WIDTH, 64, AXI address width.
MAX_BURST, 64, max beats per burst (ARLEN+1); must be ≤256 and a power of two.
MAX_OUTSTANDING, 4, max AR bursts accepted but not completed by RLAST.

Ports:
clk  in  1  clock
resetn  in  1  sync active-low reset
start  in  1  one-cycle launch pulse; sampled only in IDLE
src_addr  in  ADDR_WIDTH  start byte address, BPB-aligned (low 6 bits ignored/treated as 0)
beat_count  in  32  total beats to read
busy  out  1  high from accepted start until done
done  out  1  one-cycle pulse at completion
rd_error  out  1  sticky: any RRESP!=0 (or pattern miss when enabled); cleared on accepted start
M_AXI_ARADDR  out  ADDR_WIDTH  burst address
M_AXI_ARLEN  out  8  beats-1
M_AXI_ARSIZE  out  3  constant log2(BPB)
M_AXI_ARBURST  out  2  constant 2'b01 INCR
M_AXI_ARID/ARPROT/ARLOCK/ARCACHE/ARQOS  out  4/3/1/4/4  constant 0
M_AXI_ARVALID  out  1
M_AXI_ARREADY  in  1
M_AXI_RDATA  in  DATA_WIDTH
M_AXI_RRESP  in  2
M_AXI_RLAST  in  1
M_AXI_RVALID  in  1
M_AXI_RREADY  out  1
AXIS_TDATA  out  DATA_WIDTH
AXIS_TVALID  out  1
AXIS_TLAST  out  1
AXIS_TREADY  in  1

Behaviour:
- Reset: busy=0, done=0, rd_error=0, ARVALID=0, all counters 0, FSM=IDLE. Reset mid-transfer abandons all in-flight bursts without draining them.
- FSM states: IDLE, ISSUE, DRAIN.
- IDLE: on start, latch addr/remaining=beat_count, clear rd_error, set busy=1. If beat_count==0, go to IDLE and pulse done on the next cycle; no AR is issued. Otherwise go to ISSUE. A start pulse while busy is ignored.
- Burst length len = min(remaining, MAX_BURST, (4096 - addr[11:0])/BPB); ARLEN = len-1.
- ISSUE: assert ARVALID when outstanding < MAX_OUTSTANDING. ARADDR/ARLEN stay stable until ARREADY. On handshake: addr += len*BPB, remaining -= len, outstanding++. When remaining reaches 0, go to DRAIN.
- R path is combinational pass-through: AXIS_TDATA=RDATA, AXIS_TVALID=RVALID, RREADY=AXIS_TREADY. Zero added latency; backpressure propagates directly.
- beats_rx counts R handshakes. AXIS_TLAST=RVALID & (beats_rx==beat_count_latched-1); per-burst RLAST does not drive TLAST.
- outstanding is decremented on an R handshake with RLAST. If an AR handshake and an RLAST handshake occur in the same cycle, outstanding is unchanged.
- DRAIN: when outstanding==0 and the last beat has been handed off, go to IDLE, pulse done for 1 cycle, and drop busy in that same cycle.
- RRESP!=0 on any handshake sets rd_error. The transfer still runs to completion.
- Internal counter widths: remaining and beats_rx 32 b, outstanding clog2(MAX_OUTSTANDING+1) b. addr wraps modulo 2^ADDR_WIDTH.

Optional Feature:
- Macro PCIE_DMA_READER_PATTERN_CHECK_EN.
- With the macro: keep exp_addr, starting at the latched src_addr and incrementing by BPB per R handshake. If RDATA[63:0]!=exp_addr, set rd_error, and increment a 32-b output port pattern_errs (saturating; reset 0; cleared on start). This matches the PCIe source model's data=address pattern.
- Without the macro: no exp_addr logic and no pattern_errs port.

Decomposition:
- Package pcie_dma_pkg:
  - AXI constants: BURST_INCR=2'b01, RESP_OKAY=2'b00, BOUNDARY_4K=4096.
  - FSM state enum {IDLE, ISSUE, DRAIN}.
- Sub-module pcie_dma_burst_calc: purely combinational; computes len from (addr, remaining, MAX_BURST). Unit-testable alone.

Test Plan:
- src_addr=0x0, beat_count=128, ARREADY/TREADY=1 → two ARs (0x0 len64, 0x1000 len64), 128 stream beats, TLAST only on beat 127, done pulse once, rd_error=0.
- src_addr=0xFC0, beat_count=3 → ARs 0xFC0 ARLEN=0, then 0x1000 ARLEN=1; TDATA[63:0]=0xFC0,0x1000,0x1040.
- beat_count=0 → no ARVALID ever; done one cycle after start; busy high exactly 1 cycle.
- beat_count=640, slave delays RVALID 50 cycles → never more than 4 ARs outstanding; 10 ARs total; 640 beats.
- TREADY toggled 50% random → RREADY mirrors TREADY; no beat dropped or duplicated; data sequence monotonic by 0x40.
- Slave returns RRESP=2 on beat 5 → rd_error=1 persists after done; cleared by next start. Assert resetn=0 mid-burst → all outputs at reset values next cycle.

Source files
------------

// File: rtl/pcie_dma_pkg.sv
// Shared constants and types for the PCIe DMA read master.
// AXI encodings, 4 KB page size and the control FSM state enum.
package pcie_dma_pkg;

   localparam logic [1:0] BURST_INCR  = 2'b01;
   localparam logic [1:0] RESP_OKAY   = 2'b00;
   localparam int         BOUNDARY_4K = 4096;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ISSUE = 2'd1,
      DRAIN = 2'd2
   } dma_state_t;

endpackage

// File: rtl/pcie_dma_burst_calc.sv
// Combinational burst sizer: len = min(remaining, MAX_BURST, beats to 4K).
// Ports: page_beat = beat index of addr within its 4 KB page, remaining, len.
module pcie_dma_burst_calc
   import pcie_dma_pkg::*;
#(
   parameter int DATA_WIDTH = 512,
   parameter int MAX_BURST  = 64
) (
   input  logic [11-$clog2(DATA_WIDTH/8):0] page_beat,
   input  logic [31:0]                      remaining,
   output logic [31:0]                      len
);

   localparam int SH = $clog2(DATA_WIDTH / 8);

   logic [31:0] room;
   logic [31:0] cap;

   always_comb begin
      room = 32'(BOUNDARY_4K >> SH) - 32'(page_beat);
      cap  = (remaining < 32'(MAX_BURST)) ? remaining : 32'(MAX_BURST);
      len  = (room < cap) ? room : cap;
   end

endmodule

// File: rtl/pcie_dma_reader.sv
// AXI4 read master: splits a beat block into 4K-safe INCR bursts, streams R out.
// Ports: start/src_addr/beat_count in, busy/done/rd_error out, AXI AR/R master,
// AXI-Stream master. Macro PCIE_DMA_READER_PATTERN_CHECK_EN adds pattern_errs.
module pcie_dma_reader
   import pcie_dma_pkg::*;
#(
   parameter int DATA_WIDTH      = 512,
   parameter int ADDR_WIDTH      = 64,
   parameter int MAX_BURST       = 64,
   parameter int MAX_OUTSTANDING = 4
) (
   input  logic                  clk,
   input  logic                  resetn,
   input  logic                  start,
   input  logic [ADDR_WIDTH-1:0] src_addr,
   input  logic [31:0]           beat_count,
   output logic                  busy,
   output logic                  done,
   output logic                  rd_error,
`ifdef PCIE_DMA_READER_PATTERN_CHECK_EN
   output logic [31:0]           pattern_errs,
`endif
   output logic [ADDR_WIDTH-1:0] M_AXI_ARADDR,
   output logic [7:0]            M_AXI_ARLEN,
   output logic [2:0]            M_AXI_ARSIZE,
   output logic [1:0]            M_AXI_ARBURST,
   output logic [3:0]            M_AXI_ARID,
   output logic [2:0]            M_AXI_ARPROT,
   output logic                  M_AXI_ARLOCK,
   output logic [3:0]            M_AXI_ARCACHE,
   output logic [3:0]            M_AXI_ARQOS,
   output logic                  M_AXI_ARVALID,
   input  logic                  M_AXI_ARREADY,
   input  logic [DATA_WIDTH-1:0] M_AXI_RDATA,
   input  logic [1:0]            M_AXI_RRESP,
   input  logic                  M_AXI_RLAST,
   input  logic                  M_AXI_RVALID,
   output logic                  M_AXI_RREADY,
   output logic [DATA_WIDTH-1:0] AXIS_TDATA,
   output logic                  AXIS_TVALID,
   output logic                  AXIS_TLAST,
   input  logic                  AXIS_TREADY
);

   localparam int BPB = DATA_WIDTH / 8;
   localparam int SH  = $clog2(BPB);
   localparam int OW  = $clog2(MAX_OUTSTANDING + 1);
   localparam logic [ADDR_WIDTH-1:0] ALIGN = ~ADDR_WIDTH'(BPB - 1);

   dma_state_t            state;
   logic [ADDR_WIDTH-1:0] addr;
   logic [31:0]           remaining;
   logic [31:0]           total;
   logic [31:0]           beats_rx;
   logic [OW-1:0]         outstanding;
   logic [31:0]           len;
   logic [31:0]           len_q;
   logic                  ar_hs;
   logic                  r_hs;
   logic                  rlast_hs;
   logic                  pat_miss;
   logic                  r_bad;

   pcie_dma_burst_calc #(
      .DATA_WIDTH (DATA_WIDTH),
      .MAX_BURST  (MAX_BURST)
   ) u_calc (
      .page_beat (addr[11:SH]),
      .remaining (remaining),
      .len       (len)
   );

   assign M_AXI_ARSIZE  = 3'(SH);
   assign M_AXI_ARBURST = BURST_INCR;
   assign M_AXI_ARID    = '0;
   assign M_AXI_ARPROT  = '0;
   assign M_AXI_ARLOCK  = 1'b0;
   assign M_AXI_ARCACHE = '0;
   assign M_AXI_ARQOS   = '0;

   // R channel is a wire-through to the stream; no buffering.
   assign AXIS_TDATA   = M_AXI_RDATA;
   assign AXIS_TVALID  = M_AXI_RVALID;
   assign M_AXI_RREADY = AXIS_TREADY;
   assign AXIS_TLAST   = M_AXI_RVALID & (beats_rx == total - 32'd1);

   assign ar_hs    = M_AXI_ARVALID & M_AXI_ARREADY;
   assign r_hs     = M_AXI_RVALID & AXIS_TREADY;
   assign rlast_hs = r_hs & M_AXI_RLAST;
   assign r_bad    = r_hs & ((M_AXI_RRESP != RESP_OKAY) | pat_miss);

`ifdef PCIE_DMA_READER_PATTERN_CHECK_EN
   logic [ADDR_WIDTH-1:0] exp_addr;

   assign pat_miss = M_AXI_RDATA[63:0] != 64'(exp_addr);

   always_ff @(posedge clk) begin
      if (!resetn) begin
         exp_addr     <= '0;
         pattern_errs <= '0;
      end else if (state == IDLE && !busy && start) begin
         exp_addr     <= src_addr & ALIGN;
         pattern_errs <= '0;
      end else if (r_hs) begin
         exp_addr <= exp_addr + ADDR_WIDTH'(BPB);
         if (pat_miss && pattern_errs != 32'hFFFF_FFFF)
            pattern_errs <= pattern_errs + 32'd1;
      end
   end
`else
   assign pat_miss = 1'b0;
`endif

   always_ff @(posedge clk) begin
      if (!resetn) begin
         state         <= IDLE;
         addr          <= '0;
         remaining     <= '0;
         total         <= '0;
         beats_rx      <= '0;
         outstanding   <= '0;
         len_q         <= '0;
         busy          <= 1'b0;
         done          <= 1'b0;
         rd_error      <= 1'b0;
         M_AXI_ARVALID <= 1'b0;
         M_AXI_ARADDR  <= '0;
         M_AXI_ARLEN   <= '0;
      end else begin
         done <= 1'b0;
         if (r_hs)
            beats_rx <= beats_rx + 32'd1;
         if (r_bad)
            rd_error <= 1'b1;
         case ({ar_hs, rlast_hs})
            2'b10:   outstanding <= outstanding + OW'(1);
            2'b01:   outstanding <= outstanding - OW'(1);
            default: ;
         endcase
         unique case (state)
            IDLE: begin
               // busy set here only by a zero-length start: hold it one cycle
               if (busy) begin
                  busy <= 1'b0;
               end else if (start) begin
                  addr        <= src_addr & ALIGN;
                  remaining   <= beat_count;
                  total       <= beat_count;
                  beats_rx    <= '0;
                  outstanding <= '0;
                  rd_error    <= 1'b0;
                  busy        <= 1'b1;
                  if (beat_count == 32'd0)
                     done <= 1'b1;
                  else
                     state <= ISSUE;
               end
            end
            ISSUE: begin
               if (!M_AXI_ARVALID &&
                   outstanding < OW'(MAX_OUTSTANDING)) begin
                  M_AXI_ARVALID <= 1'b1;
                  M_AXI_ARADDR  <= addr;
                  M_AXI_ARLEN   <= 8'(len - 32'd1);
                  len_q         <= len;
               end else if (ar_hs) begin
                  M_AXI_ARVALID <= 1'b0;
                  addr          <= addr + (ADDR_WIDTH'(len_q) << SH);
                  remaining     <= remaining - len_q;
                  if (remaining == len_q)
                     state <= DRAIN;
               end
            end
            DRAIN: begin
               if (outstanding == '0 && beats_rx == total) begin
                  state <= IDLE;
                  busy  <= 1'b0;
                  done  <= 1'b1;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_pcie_dma_reader.sv
// Self-checking bench for pcie_dma_reader with a randomized AXI slave model.
// Expected bursts and beats come from a page-splitting reference model.
module tb_pcie_dma_reader;

   localparam int DW = 512;
   localparam int AW = 64;
   localparam int MAXO = 4;

   logic          clk = 1'b0;
   logic          resetn = 1'b0;
   logic          start = 1'b0;
   logic [AW-1:0] src_addr = '0;
   logic [31:0]   beat_count = '0;
   logic          busy, done, rd_error;
`ifdef PCIE_DMA_READER_PATTERN_CHECK_EN
   logic [31:0]   pattern_errs;
`endif
   logic [AW-1:0] araddr;
   logic [7:0]    arlen;
   logic [2:0]    arsize;
   logic [1:0]    arburst;
   logic [3:0]    arid;
   logic [2:0]    arprot;
   logic          arlock;
   logic [3:0]    arcache;
   logic [3:0]    arqos;
   logic          arvalid;
   logic          arready = 1'b0;
   logic [DW-1:0] rdata = '0;
   logic [1:0]    rresp = '0;
   logic          rlast = 1'b0;
   logic          rvalid = 1'b0;
   logic          rready;
   logic [DW-1:0] tdata;
   logic          tvalid, tlast;
   logic          tready = 1'b0;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   pcie_dma_reader #(
      .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .MAX_BURST(64), .MAX_OUTSTANDING(MAXO)
   ) dut (
      .clk(clk), .resetn(resetn), .start(start), .src_addr(src_addr),
      .beat_count(beat_count), .busy(busy), .done(done), .rd_error(rd_error),
`ifdef PCIE_DMA_READER_PATTERN_CHECK_EN
      .pattern_errs(pattern_errs),
`endif
      .M_AXI_ARADDR(araddr), .M_AXI_ARLEN(arlen), .M_AXI_ARSIZE(arsize),
      .M_AXI_ARBURST(arburst), .M_AXI_ARID(arid), .M_AXI_ARPROT(arprot),
      .M_AXI_ARLOCK(arlock), .M_AXI_ARCACHE(arcache), .M_AXI_ARQOS(arqos),
      .M_AXI_ARVALID(arvalid), .M_AXI_ARREADY(arready),
      .M_AXI_RDATA(rdata), .M_AXI_RRESP(rresp), .M_AXI_RLAST(rlast),
      .M_AXI_RVALID(rvalid), .M_AXI_RREADY(rready),
      .AXIS_TDATA(tdata), .AXIS_TVALID(tvalid), .AXIS_TLAST(tlast),
      .AXIS_TREADY(tready)
   );

   // ---------------- slave model configuration ----------------
   bit ar_rand = 1'b0;
   bit t_rand  = 1'b0;
   int r_delay = 0;
   int err_idx = -1;

   typedef struct {
      logic [63:0] a;
      bit          last;
      int          t;
   } sb_t;

   typedef struct {
      logic [63:0] a;
      logic [7:0]  l;
   } ar_t;

   sb_t beatq[$];
   int  cyc = 0;
   int  sent_idx = 0;

   always @(posedge clk) begin
      if (!resetn) begin
         beatq.delete();
         rvalid  <= 1'b0;
         rlast   <= 1'b0;
         arready <= 1'b0;
         tready  <= 1'b0;
      end else begin
         cyc++;
         if (start) sent_idx = 0;
         if (arvalid && arready)
            for (int i = 0; i <= int'(arlen); i++)
               beatq.push_back('{araddr + 64'(i * 64), i == int'(arlen),
                                 cyc + r_delay});
         if (!rvalid || rready) begin
            if (beatq.size() > 0 && beatq[0].t <= cyc) begin
               sb_t b;
               b = beatq.pop_front();
               rvalid <= 1'b1;
               rdata  <= {$urandom, $urandom, $urandom, $urandom,
                          $urandom, $urandom, $urandom, $urandom,
                          $urandom, $urandom, $urandom, $urandom,
                          b.a};
               rlast  <= b.last;
               rresp  <= (sent_idx == err_idx) ? 2'd2 : 2'd0;
               sent_idx++;
            end else begin
               rvalid <= 1'b0;
            end
         end
         arready <= ar_rand ? 1'($urandom % 2) : 1'b1;
         tready  <= t_rand ? 1'($urandom % 2) : 1'b1;
      end
   end

   // ---------------- monitor (records only) ----------------
   ar_t         ar_log[$];
   logic [63:0] d_log[$];
   bit          l_log[$];
   int          out_m = 0;
   int          max_out = 0;
   int          rr_bad = 0;
   int          done_cnt = 0;

   always @(negedge clk) begin
      if (resetn) begin
         if (arvalid && arready) begin
            ar_log.push_back('{araddr, arlen});
            out_m++;
         end
         if (rvalid && rready && rlast) out_m--;
         if (out_m > max_out) max_out = out_m;
         if (tvalid && tready) begin
            d_log.push_back(tdata[63:0]);
            l_log.push_back(tlast);
         end
         if (rready !== tready) rr_bad++;
         if (done) done_cnt++;
      end
   end

   task automatic clear_logs();
      ar_log.delete();
      d_log.delete();
      l_log.delete();
      out_m    = 0;
      max_out  = 0;
      rr_bad   = 0;
      done_cnt = 0;
   endtask

   // Reference: split [a, a+n beats) into bursts of <=64 beats not crossing 4K.
   task automatic model_ars(input logic [63:0] a0, input int n,
                            output ar_t q[$]);
      logic [63:0] a;
      int rem, room, l;
      q.delete();
      a = a0 & ~64'h3F;
      rem = n;
      while (rem > 0) begin
         room = (4096 - int'(a % 4096)) / 64;
         l = rem;
         if (l > 64) l = 64;
         if (l > room) l = room;
         q.push_back('{a, 8'(l - 1)});
         a += 64'(l * 64);
         rem -= l;
      end
   endtask

   task automatic run_xfer(input string nm, input logic [63:0] a, input int n,
                           input bit arr, input bit tr, input int dly,
                           input int eidx);
      ar_t exp_ar[$];
      logic [63:0] base;
      int c;
      ar_rand = arr;
      t_rand  = tr;
      r_delay = dly;
      err_idx = eidx;
      model_ars(a, n, exp_ar);
      base = a & ~64'h3F;
      clear_logs();
      @(negedge clk);
      src_addr = a;
      beat_count = 32'(n);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      checks++;
      if (busy !== 1'b1 || rd_error !== 1'b0) begin
         errors++;
         $display("FAIL %s accept: busy=%b rd_error=%b, need 1/0",
                  nm, busy, rd_error);
      end
      c = 0;
      while (done_cnt == 0 && c < 20000) begin
         @(negedge clk);
         c++;
      end
      checks++;
      if (done_cnt == 0) begin
         errors++;
         $display("FAIL %s timeout: no done after %0d cycles", nm, c);
      end
      repeat (5) @(negedge clk);
      checks++;
      if (done_cnt !== 1 || busy !== 1'b0) begin
         errors++;
         $display("FAIL %s done: pulses=%0d busy=%b, need 1/0",
                  nm, done_cnt, busy);
      end
      checks++;
      if (ar_log.size() != exp_ar.size()) begin
         errors++;
         $display("FAIL %s ar_count: got %0d need %0d",
                  nm, ar_log.size(), exp_ar.size());
      end else begin
         for (int i = 0; i < exp_ar.size(); i++) begin
            checks++;
            if (ar_log[i].a !== exp_ar[i].a || ar_log[i].l !== exp_ar[i].l) begin
               errors++;
               $display("FAIL %s ar[%0d]: got %h/%0d need %h/%0d", nm, i,
                        ar_log[i].a, ar_log[i].l, exp_ar[i].a, exp_ar[i].l);
            end
         end
      end
      checks++;
      if (d_log.size() != n) begin
         errors++;
         $display("FAIL %s beats: got %0d need %0d", nm, d_log.size(), n);
      end else begin
         for (int i = 0; i < n; i++) begin
            checks++;
            if (d_log[i] !== base + 64'(i * 64) || l_log[i] !== (i == n - 1)) begin
               errors++;
               $display("FAIL %s beat[%0d]: data %h last %b need %h %b", nm, i,
                        d_log[i], l_log[i], base + 64'(i * 64), i == n - 1);
            end
         end
      end
      checks++;
      if (max_out > MAXO || rr_bad != 0) begin
         errors++;
         $display("FAIL %s flow: max_out=%0d rready_miss=%0d need <=%0d/0",
                  nm, max_out, rr_bad, MAXO);
      end
      checks++;
      if (rd_error !== (eidx >= 0 && eidx < n)) begin
         errors++;
         $display("FAIL %s rd_error: got %b need %b", nm, rd_error,
                  eidx >= 0 && eidx < n);
      end
`ifdef PCIE_DMA_READER_PATTERN_CHECK_EN
      checks++;
      if (pattern_errs !== 32'd0) begin
         errors++;
         $display("FAIL %s pattern_errs: got %0d need 0", nm, pattern_errs);
      end
`endif
   endtask

   task automatic test_reset();
      resetn = 1'b0;
      repeat (3) @(negedge clk);
      checks++;
      if (busy !== 0 || done !== 0 || rd_error !== 0 || arvalid !== 0) begin
         errors++;
         $display("FAIL reset: busy=%b done=%b err=%b arvalid=%b need 0",
                  busy, done, rd_error, arvalid);
      end
      resetn = 1'b1;
      @(negedge clk);
   endtask

   task automatic test_constants();
      checks++;
      if (arsize !== 3'd6 || arburst !== 2'b01 ||
          {arid, arprot, arlock, arcache, arqos} !== 16'd0) begin
         errors++;
         $display("FAIL ar_const: size=%0d burst=%b other=%h need 6/01/0",
                  arsize, arburst, {arid, arprot, arlock, arcache, arqos});
      end
   endtask

   task automatic test_zero_len();
      clear_logs();
      @(negedge clk);
      src_addr = 64'h2000;
      beat_count = 32'd0;
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      checks++;
      if (done !== 1'b1 || busy !== 1'b1) begin
         errors++;
         $display("FAIL zero_len t1: done=%b busy=%b need 1/1", done, busy);
      end
      @(negedge clk);
      checks++;
      if (done !== 1'b0 || busy !== 1'b0) begin
         errors++;
         $display("FAIL zero_len t2: done=%b busy=%b need 0/0", done, busy);
      end
      repeat (10) @(negedge clk);
      checks++;
      if (ar_log.size() != 0 || done_cnt != 1) begin
         errors++;
         $display("FAIL zero_len ar: ars=%0d dones=%0d need 0/1",
                  ar_log.size(), done_cnt);
      end
   endtask

   task automatic test_outstanding();
      run_xfer("outstanding", 64'h0, 640, 1'b0, 1'b0, 50, -1);
      checks++;
      if (max_out != MAXO) begin
         errors++;
         $display("FAIL outstanding max: got %0d need %0d", max_out, MAXO);
      end
   endtask

   task automatic test_busy_start();
      // A second start while busy must not restart or extend the transfer.
      ar_rand = 1'b0;
      t_rand = 1'b0;
      r_delay = 20;
      err_idx = -1;
      clear_logs();
      @(negedge clk);
      src_addr = 64'h8000;
      beat_count = 32'd4;
      start = 1'b1;
      @(negedge clk);
      src_addr = 64'h9000;
      beat_count = 32'd100;
      repeat (3) @(negedge clk);
      start = 1'b0;
      repeat (80) @(negedge clk);
      checks++;
      if (d_log.size() != 4 || done_cnt != 1 || ar_log.size() != 1) begin
         errors++;
         $display("FAIL busy_start: beats=%0d dones=%0d ars=%0d need 4/1/1",
                  d_log.size(), done_cnt, ar_log.size());
      end
   endtask

   task automatic test_reset_mid();
      ar_rand = 1'b0;
      t_rand = 1'b0;
      r_delay = 0;
      err_idx = 2;
      clear_logs();
      @(negedge clk);
      src_addr = 64'h4000;
      beat_count = 32'd256;
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      repeat (20) @(negedge clk);
      resetn = 1'b0;
      @(negedge clk);
      checks++;
      if (busy !== 0 || done !== 0 || rd_error !== 0 ||
          arvalid !== 0 || tvalid !== 0) begin
         errors++;
         $display("FAIL reset_mid: busy=%b done=%b err=%b arv=%b tv=%b need 0",
                  busy, done, rd_error, arvalid, tvalid);
      end
      repeat (2) @(negedge clk);
      resetn = 1'b1;
      repeat (2) @(negedge clk);
   endtask

   task automatic test_random();
      logic [63:0] a;
      for (int k = 0; k < 8; k++) begin
         a = {32'd0, $urandom} & 64'h000F_FFFF;
         if ($urandom % 2) a[11:6] = 6'(63 - $urandom_range(0, 3));
         run_xfer("random", a, $urandom_range(1, 300), 1'($urandom % 2),
                  1'($urandom % 2), $urandom_range(0, 8), -1);
      end
   endtask

   initial begin
      test_reset();
      test_constants();
      run_xfer("basic", 64'h0, 128, 1'b0, 1'b0, 0, -1);
      run_xfer("cross_4k", 64'hFC0, 3, 1'b0, 1'b0, 0, -1);
      run_xfer("unaligned", 64'h1F7B, 70, 1'b1, 1'b0, 2, -1);
      test_zero_len();
      test_outstanding();
      run_xfer("backpressure", 64'h3000, 200, 1'b0, 1'b1, 0, -1);
      run_xfer("rresp_err", 64'h5000, 20, 1'b0, 1'b0, 0, 5);
      run_xfer("err_clear", 64'h6000, 8, 1'b0, 1'b0, 0, -1);
      test_busy_start();
      test_reset_mid();
      run_xfer("after_reset", 64'h7FC0, 130, 1'b1, 1'b1, 3, -1);
      test_random();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
